z8_stack: RTL and testbench
===========================

# z8_stack

Parametrised hardware stack for the z8 processor core. It backs the PSHR, PSHD and POP instructions, and it replaces the fixed-size stack region in data memory with a dedicated LIFO of configurable width and depth. It adds sticky overflow/underflow error flags and a push-and-pop-in-one-cycle replace operation. It sits beside the register file and is driven by the EXECUTE/WRITEBACK stages of the core control FSM.

## Interface
Parameters:
- DATA_WIDTH, 8, bit width of each stack entry.
- DEPTH, 16, number of entries; legal range is 2 or more, not necessarily a power of two.
- PTR_W, $clog2(DEPTH+1), width of the stack pointer. Derived; do not override.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- clear_i  in  1  synchronous flush: empties the stack and clears both error flags.
- push_i  in  1  push request, sampled every cycle.
- push_data_i  in  DATA_WIDTH  value to push.
- pop_i  in  1  pop request, sampled every cycle.
- pop_data_o  out  DATA_WIDTH  popped value, registered.
- pop_valid_o  out  1  one-cycle pulse marking pop_data_o as valid.
- sp_o  out  PTR_W  current entry count; 0 means empty.
- empty_o  out  1  sp_o == 0.
- full_o  out  1  sp_o == DEPTH.
- overflow_o  out  1  sticky; set by a push that is rejected because the stack is full.
- underflow_o  out  1  sticky; set by a pop that is rejected because the stack is empty.
- top_o  out  DATA_WIDTH  present only when Z8_STACK_PEEK_EN is defined.

## Operation
Each cycle is evaluated in this priority order:
1. clear_i: sp set to 0, overflow_o and underflow_o cleared. Any push or pop in the same cycle is ignored. pop_valid_o is 0 next cycle.
2. push_i and pop_i, not empty (replace):
   - pop_data_o takes mem[sp-1] and pop_valid_o pulses.
   - mem[sp-1] takes push_data_i; sp is unchanged.
   - This is legal when full and is not an overflow.
3. push_i and pop_i, empty:
   - The pop is rejected and underflow_o is set.
   - The push proceeds: mem[0] takes push_data_i and sp becomes 1.
4. push_i only:
   - Not full: mem[sp] takes push_data_i and sp increments.
   - Full: data is dropped, sp is unchanged, overflow_o is set.
5. pop_i only:
   - Not empty: pop_data_o takes mem[sp-1], pop_valid_o pulses, sp decrements.
   - Empty: pop_data_o is held, pop_valid_o stays 0, underflow_o is set.

General rules:
- Memory contents are never cleared. Entries at or above sp are don't-care.
- The flags stay set until clear_i or reset.

## Timing
- Reset values: sp_o=0, empty_o=1, full_o=0, overflow_o=0, underflow_o=0, pop_data_o=0, pop_valid_o=0, top_o=0.
- Push latency: sp_o, empty_o and full_o reflect the push on the cycle after the request edge.
- Pop latency: pop_data_o and pop_valid_o are valid exactly one cycle after the pop_i cycle. pop_valid_o is high for one cycle per accepted pop.
- Back-to-back pops return successive entries with no bubbles.
- A push followed by a pop on the next cycle returns the just-pushed value.
- No ready/stall: every request resolves in the cycle it is sampled.
- Reset asserted mid-sequence forces all outputs to their reset values immediately, without waiting for a clock edge.

## Configuration
Macro: Z8_STACK_PEEK_EN.
- Defined: port top_o is present.
  - Its value is mem[sp-1] after every edge, and 0 when empty.
  - It is registered, so it updates in the same cycle as sp_o.
  - It lets POP-free instructions read the stack top.
- Undefined: port top_o and its register are absent. All other behaviour is identical.

## Structure
- The instruction_set package gains:
  - STACK_OPS_T enum {STK_NOP, STK_PUSH, STK_POP, STK_REPLACE}, the decoded operation the control FSM drives.
  - Parameters STACK_DEPTH = 16 and STACK_WIDTH = 8, the core-level defaults.
- Sub-module z8_stack_mem holds the storage: DEPTH x DATA_WIDTH registers with one synchronous write port and one combinational read port, and no reset.
- z8_stack owns the pointer, flags and output registers.

## Test plan
All scenarios use DEPTH=4, DATA_WIDTH=8.
- Reset, then idle: sp_o=0, empty_o=1, all flags 0, pop_valid_o=0.
- Push 0x11, 0x22, 0x33, 0x44, then pop four times: pops return 0x44, 0x33, 0x22, 0x11 on consecutive cycles; full_o=1 after the fourth push; empty_o=1 at the end.
- With the stack full, push 0x55: sp_o stays 4, overflow_o=1; a subsequent pop returns 0x44.
- With the stack empty, pop: pop_valid_o=0 and underflow_o=1; then clear_i: underflow_o=0.
- Hold 0xAA, then push 0xBB and pop in the same cycle: pop_data_o=0xAA, sp_o stays 1; the next pop returns 0xBB. With the stack full, the same replace gives no overflow.
- Push 0x77, then assert rst_n low mid-cycle: outputs return to reset values asynchronously. With PEEK enabled, top_o=0x77 after the push and 0 after reset.

Source files
------------

// File: rtl/z8_stack_pkg.sv
// z8_stack_pkg: decoded stack operations and core-level stack defaults
// shared by the z8 stack and the control FSM that drives it.
package z8_stack_pkg;

  localparam int STACK_DEPTH = 16;
  localparam int STACK_WIDTH = 8;

  typedef enum logic [1:0] {
    STK_NOP,
    STK_PUSH,
    STK_POP,
    STK_REPLACE
  } STACK_OPS_T;

  function automatic STACK_OPS_T decode_op(input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return STK_PUSH;
      2'b01:   return STK_POP;
      2'b11:   return STK_REPLACE;
      default: return STK_NOP;
    endcase
  endfunction

  // Storage address width; a single-bit address is kept even for tiny depths.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/z8_stack_if.sv
// z8_stack_if: request/response bundle between the core control FSM and the
// stack. top_o exists only when Z8_STACK_PEEK_EN is defined.
interface z8_stack_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_W      = 5
);

  logic                  clear_i;
  logic                  push_i;
  logic [DATA_WIDTH-1:0] push_data_i;
  logic                  pop_i;
  logic [DATA_WIDTH-1:0] pop_data_o;
  logic                  pop_valid_o;
  logic [PTR_W-1:0]      sp_o;
  logic                  empty_o;
  logic                  full_o;
  logic                  overflow_o;
  logic                  underflow_o;
`ifdef Z8_STACK_PEEK_EN
  logic [DATA_WIDTH-1:0] top_o;

  modport master (
    output clear_i, push_i, push_data_i, pop_i,
    input  pop_data_o, pop_valid_o, sp_o, empty_o, full_o,
           overflow_o, underflow_o, top_o
  );

  modport slave (
    input  clear_i, push_i, push_data_i, pop_i,
    output pop_data_o, pop_valid_o, sp_o, empty_o, full_o,
           overflow_o, underflow_o, top_o
  );
`else
  modport master (
    output clear_i, push_i, push_data_i, pop_i,
    input  pop_data_o, pop_valid_o, sp_o, empty_o, full_o,
           overflow_o, underflow_o
  );

  modport slave (
    input  clear_i, push_i, push_data_i, pop_i,
    output pop_data_o, pop_valid_o, sp_o, empty_o, full_o,
           overflow_o, underflow_o
  );
`endif

endinterface

// File: rtl/z8_stack_mem.sv
// z8_stack_mem: DEPTH x DATA_WIDTH register storage with one synchronous
// write port and one combinational read port; contents are never reset.
module z8_stack_mem
  import z8_stack_pkg::*;
#(
  parameter int DATA_WIDTH = STACK_WIDTH,
  parameter int DEPTH      = STACK_DEPTH
) (
  input  logic                           clk,
  input  logic                           we_i,
  input  logic [addr_width(DEPTH)-1:0]   waddr_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic [addr_width(DEPTH)-1:0]   raddr_i,
  output logic [DATA_WIDTH-1:0]          rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/z8_stack.sv
// z8_stack: LIFO for PSHR/PSHD/POP with sticky overflow/underflow flags and a
// same-cycle replace. Define Z8_STACK_PEEK_EN to add the registered top_o port.
module z8_stack
  import z8_stack_pkg::*;
#(
  parameter int DATA_WIDTH = STACK_WIDTH,
  parameter int DEPTH      = STACK_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  z8_stack_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int AW    = addr_width(DEPTH);
  localparam logic [PTR_W-1:0] SP_FULL = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] SP_ONE  = PTR_W'(1);

  logic [PTR_W-1:0]      sp_q, sp_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
  logic                  pop_valid_q, pop_valid_d;

  logic                  empty;
  logic                  full;
  STACK_OPS_T            op;
  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [AW-1:0]         mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] stack_top;

  assign empty = (sp_q == '0);
  assign full  = (sp_q == SP_FULL);
  assign op    = decode_op(bus.push_i, bus.pop_i);

  z8_stack_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (bus.push_data_i),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    sp_d        = sp_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    if (bus.clear_i) begin
      sp_d        = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      case (op)
        STK_REPLACE: begin
          mem_we = 1'b1;
          if (empty) begin
            underflow_d = 1'b1;
            sp_d        = SP_ONE;
          end else begin
            mem_waddr   = AW'(sp_q - SP_ONE);
            pop_data_d  = stack_top;
            pop_valid_d = 1'b1;
          end
        end
        STK_PUSH: begin
          if (full) begin
            overflow_d = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = AW'(sp_q);
            sp_d      = sp_q + SP_ONE;
          end
        end
        STK_POP: begin
          if (empty) begin
            underflow_d = 1'b1;
          end else begin
            pop_data_d  = stack_top;
            pop_valid_d = 1'b1;
            sp_d        = sp_q - SP_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
    end
  end

`ifdef Z8_STACK_PEEK_EN
  // top_q always mirrors mem[sp-1], so the read port looks one entry lower
  // to supply the new top after a pop.
  logic [DATA_WIDTH-1:0] top_q, top_d;

  assign stack_top = top_q;
  assign mem_raddr = (sp_q >= PTR_W'(2)) ? AW'(sp_q - PTR_W'(2)) : '0;

  always_comb begin
    top_d = top_q;
    if (bus.clear_i) begin
      top_d = '0;
    end else if (bus.push_i && (bus.pop_i || !full)) begin
      top_d = bus.push_data_i;
    end else if (bus.pop_i && !bus.push_i && !empty) begin
      top_d = (sp_q == SP_ONE) ? '0 : mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q <= '0;
    end else begin
      top_q <= top_d;
    end
  end

  assign bus.top_o = top_q;
`else
  assign stack_top = mem_rdata;
  assign mem_raddr = empty ? '0 : AW'(sp_q - SP_ONE);
`endif

  assign bus.sp_o        = sp_q;
  assign bus.empty_o     = empty;
  assign bus.full_o      = full;
  assign bus.overflow_o  = overflow_q;
  assign bus.underflow_o = underflow_q;
  assign bus.pop_data_o  = pop_data_q;
  assign bus.pop_valid_o = pop_valid_q;

endmodule

// File: tb/tb_z8_stack.sv
// tb_z8_stack: directed vectors against a queue-based LIFO model of z8_stack
// (DEPTH=4, DATA_WIDTH=8); honours Z8_STACK_PEEK_EN for top_o.
module tb_z8_stack;

  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int PTR_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   nVec = 0;
  int   nFail = 0;

  logic [DW-1:0] mq[$];
  logic          mOvf = 1'b0;
  logic          mUnf = 1'b0;
  logic          mPv = 1'b0;
  logic [DW-1:0] mPd = '0;

  z8_stack_if #(.DATA_WIDTH(DW), .PTR_W(PTR_W)) bus ();

  z8_stack #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelTop();
    if (mq.size() == 0) return 32'h0;
    return 32'(mq[mq.size() - 1]);
  endfunction

  // LIFO model: decides each edge's outcome from the request rules on a queue.
  task automatic modelStep();
    mPv = 1'b0;
    if (bus.clear_i) begin
      mq.delete();
      mOvf = 1'b0;
      mUnf = 1'b0;
    end else if (bus.push_i && bus.pop_i) begin
      if (mq.size() > 0) begin
        mPd = mq[mq.size() - 1];
        mPv = 1'b1;
        mq[mq.size() - 1] = bus.push_data_i;
      end else begin
        mUnf = 1'b1;
        mq.push_back(bus.push_data_i);
      end
    end else if (bus.push_i) begin
      if (mq.size() < DEPTH) mq.push_back(bus.push_data_i);
      else mOvf = 1'b1;
    end else if (bus.pop_i) begin
      if (mq.size() > 0) begin
        mPd = mq.pop_back();
        mPv = 1'b1;
      end else begin
        mUnf = 1'b1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        mOvf = 1'b0;
        mUnf = 1'b0;
        mPv  = 1'b0;
        mPd  = '0;
      end else begin
        modelStep();
      end
    end
  end

  task automatic checkOutput();
    cmp("sp", 32'(bus.sp_o), 32'(mq.size()));
    cmp("empty", 32'(bus.empty_o), 32'(mq.size() == 0));
    cmp("full", 32'(bus.full_o), 32'(mq.size() == DEPTH));
    cmp("overflow", 32'(bus.overflow_o), 32'(mOvf));
    cmp("underflow", 32'(bus.underflow_o), 32'(mUnf));
    cmp("pop_valid", 32'(bus.pop_valid_o), 32'(mPv));
    cmp("pop_data", 32'(bus.pop_data_o), 32'(mPd));
`ifdef Z8_STACK_PEEK_EN
    cmp("top", 32'(bus.top_o), modelTop());
`endif
  endtask

  initial begin
    #7;
    forever begin
      @(negedge clk);
      checkOutput();
    end
  end

  task automatic applyStimulus(input logic c, input logic pu, input logic [DW-1:0] d, input logic po);
    @(negedge clk);
    bus.clear_i     = c;
    bus.push_i      = pu;
    bus.push_data_i = d;
    bus.pop_i       = po;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] pushVals [4];
    logic [DW-1:0] popVals [4];
    pushVals = '{8'h11, 8'h22, 8'h33, 8'h44};
    popVals  = '{8'h44, 8'h33, 8'h22, 8'h11};
    bus.clear_i     = 1'b0;
    bus.push_i      = 1'b0;
    bus.push_data_i = '0;
    bus.pop_i       = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    cmp("rst_sp", 32'(bus.sp_o), 32'd0);
    cmp("rst_empty", 32'(bus.empty_o), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(0, 0, 8'h00, 0);
    cmp("idle_sp", 32'(bus.sp_o), 32'd0);
    cmp("idle_empty", 32'(bus.empty_o), 32'd1);
    cmp("idle_flags", {30'd0, bus.overflow_o, bus.underflow_o}, 32'd0);
    cmp("idle_valid", 32'(bus.pop_valid_o), 32'd0);

    for (int i = 0; i < 4; i++) applyStimulus(0, 1, pushVals[i], 0);
    cmp("fill_full", 32'(bus.full_o), 32'd1);
    cmp("fill_sp", 32'(bus.sp_o), 32'd4);

    applyStimulus(0, 1, 8'h55, 0);
    cmp("ovf_sp", 32'(bus.sp_o), 32'd4);
    cmp("ovf_flag", 32'(bus.overflow_o), 32'd1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 8'h00, 1);
      cmp("pop_valid_seq", 32'(bus.pop_valid_o), 32'd1);
      cmp("pop_data_seq", 32'(bus.pop_data_o), 32'(popVals[i]));
    end
    cmp("drain_empty", 32'(bus.empty_o), 32'd1);

    applyStimulus(0, 0, 8'h00, 1);
    cmp("unf_valid", 32'(bus.pop_valid_o), 32'd0);
    cmp("unf_flag", 32'(bus.underflow_o), 32'd1);
    applyStimulus(1, 0, 8'h00, 0);
    cmp("clr_unf", 32'(bus.underflow_o), 32'd0);
    cmp("clr_ovf", 32'(bus.overflow_o), 32'd0);

    applyStimulus(0, 1, 8'hAA, 0);
    applyStimulus(0, 1, 8'hBB, 1);
    cmp("rep_data", 32'(bus.pop_data_o), 32'hAA);
    cmp("rep_sp", 32'(bus.sp_o), 32'd1);
    applyStimulus(0, 0, 8'h00, 1);
    cmp("rep_next", 32'(bus.pop_data_o), 32'hBB);

    for (int i = 1; i <= 4; i++) applyStimulus(0, 1, 8'(i), 0);
    applyStimulus(0, 1, 8'h99, 1);
    cmp("repfull_data", 32'(bus.pop_data_o), 32'h04);
    cmp("repfull_ovf", 32'(bus.overflow_o), 32'd0);
    cmp("repfull_sp", 32'(bus.sp_o), 32'd4);
    applyStimulus(0, 0, 8'h00, 1);
    cmp("repfull_pop", 32'(bus.pop_data_o), 32'h99);
    applyStimulus(1, 0, 8'h00, 0);

    applyStimulus(0, 1, 8'hC3, 1);
    cmp("repempty_unf", 32'(bus.underflow_o), 32'd1);
    cmp("repempty_sp", 32'(bus.sp_o), 32'd1);
    cmp("repempty_valid", 32'(bus.pop_valid_o), 32'd0);
    applyStimulus(0, 0, 8'h00, 1);
    cmp("repempty_pop", 32'(bus.pop_data_o), 32'hC3);

    applyStimulus(0, 1, 8'h5A, 0);
    applyStimulus(0, 0, 8'h00, 1);
    cmp("push_then_pop", 32'(bus.pop_data_o), 32'h5A);

    applyStimulus(0, 1, 8'h66, 0);
    applyStimulus(1, 1, 8'h67, 0);
    cmp("clr_push_sp", 32'(bus.sp_o), 32'd0);
    cmp("clr_push_unf", 32'(bus.underflow_o), 32'd0);

    applyStimulus(0, 0, 8'h00, 1);
    applyStimulus(0, 1, 8'h77, 0);
    cmp("pre_rst_sp", 32'(bus.sp_o), 32'd1);
`ifdef Z8_STACK_PEEK_EN
    cmp("peek_top", 32'(bus.top_o), 32'h77);
`endif
    #2;
    rst_n = 1'b0;
    bus.push_i = 1'b0;
    #1;
    cmp("arst_sp", 32'(bus.sp_o), 32'd0);
    cmp("arst_empty", 32'(bus.empty_o), 32'd1);
    cmp("arst_unf", 32'(bus.underflow_o), 32'd0);
    cmp("arst_data", 32'(bus.pop_data_o), 32'd0);
`ifdef Z8_STACK_PEEK_EN
    cmp("arst_top", 32'(bus.top_o), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 8'h00, 0);
    applyStimulus(0, 0, 8'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
